// File: rtl/fmps_readout_sequencer_if.sv
// fmps_readout_sequencer_if
//   Bundles the FMPS readout port (address out, data back one cycle later)
//   and the MicroBlaze single-word read channel that shares it.
//   master : the sequencer (drives the readout address, answers uB reads)
//   slave  : readout memory / MicroBlaze side
//   fmpsReadoutAddress  master->slave  readout address
//   fmpsReadout         slave->master  readout data, valid 1 cycle after address
//   uBreadStrobe        slave->master  single-cycle read request
//   uBreadAddress       slave->master  read address, sampled with uBreadStrobe
//   uBreadAck           master->slave  1-cycle pulse when uBreadData updates
//   uBreadData          master->slave  last uB read result
interface fmps_readout_sequencer_if #(
    parameter int INDEX_WIDTH = 5
);
    logic [INDEX_WIDTH-1:0] fmpsReadoutAddress;
    logic [31:0]            fmpsReadout;
    logic                   uBreadStrobe;
    logic [INDEX_WIDTH-1:0] uBreadAddress;
    logic                   uBreadAck;
    logic [31:0]            uBreadData;

    modport master (
        output fmpsReadoutAddress,
        input  fmpsReadout,
        input  uBreadStrobe,
        input  uBreadAddress,
        output uBreadAck,
        output uBreadData
    );

    modport slave (
        input  fmpsReadoutAddress,
        output fmpsReadout,
        output uBreadStrobe,
        output uBreadAddress,
        input  uBreadAck,
        input  uBreadData
    );
endinterface

// File: rtl/fmps_readout_sequencer.sv
// fmps_readout_sequencer
//   Once per FA cycle, on a fresh rising edge of readoutValid, sweeps the FMPS
//   readout port over nodes 0..n-1 (n = min(fmpsCount, 2**INDEX_WIDTH)),
//   gathers each node's trip bit and publishes bitmap, count and strobes.
//   The same port serves MicroBlaze single-word reads when no sweep needs it.
// Ports
//   sysClk, sysResetN    clock, asynchronous active-low reset
//   FAstrobe             aborts a sweep in SWEEP or DRAIN
//   readoutValid         level; its 0->1 edge starts a sweep from IDLE
//   fmpsCount            number of nodes to sweep (clamped to 2**INDEX_WIDTH)
//   bus                  readout port + uB read channel (master side)
//   tripBitmap/tripCount published result of the last completed sweep
//   tripStrobe           pulse at completion when tripCount != 0
//   sweepDone            pulse at every completed sweep
//   sweepAborted         pulse when FAstrobe aborts a sweep
//   busy                 high in SWEEP and DRAIN
//   seqno                completed-sweep counter, wraps
module fmps_readout_sequencer #(
    parameter int INDEX_WIDTH = 5,
    parameter int TRIP_BIT    = 0,
    parameter int SEQNO_WIDTH = 4
) (
    input  logic                          sysClk,
    input  logic                          sysResetN,
    input  logic                          FAstrobe,
    input  logic                          readoutValid,
    input  logic [INDEX_WIDTH:0]          fmpsCount,
    fmps_readout_sequencer_if.master      bus,
    output logic [(2**INDEX_WIDTH)-1:0]   tripBitmap,
    output logic [INDEX_WIDTH:0]          tripCount,
    output logic                          tripStrobe,
    output logic                          sweepDone,
    output logic                          sweepAborted,
    output logic                          busy,
    output logic [SEQNO_WIDTH-1:0]        seqno
);
    localparam int NODES = 2**INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0] MAX_COUNT = {1'b1, {INDEX_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 nextState_s;
    logic                   rvPrev_r;
    logic                   start_s;
    logic                   abort_s;
    logic                   serve_s;
    logic [INDEX_WIDTH:0]   effCount_s;
    logic [INDEX_WIDTH-1:0] effLast_s;
    logic [INDEX_WIDTH-1:0] addr_r;
    logic [INDEX_WIDTH-1:0] lastIdx_r;
    logic                   capValid_r;
    logic [INDEX_WIDTH-1:0] capIdx_r;
    logic                   capBit_s;
    logic [NODES-1:0]       capMask_s;
    logic [NODES-1:0]       workBitmap_r;
    logic [NODES-1:0]       nextWorkBitmap_s;
    logic [INDEX_WIDTH:0]   workCount_r;
    logic [INDEX_WIDTH:0]   nextWorkCount_s;
    logic                   pending_r;
    logic [INDEX_WIDTH-1:0] ubAddr_r;
    logic                   ubFetch_r;
    logic                   ubCap_r;
    logic                   ubAck_r;
    logic [31:0]            ubData_r;

    assign start_s = (state_r == IDLE) && readoutValid && !rvPrev_r;
    assign abort_s = ((state_r == SWEEP) || (state_r == DRAIN)) && FAstrobe;
    // The uB address is loaded as the FSM settles into IDLE, so it is on the
    // port during an IDLE cycle; a sweep start keeps the next state out of
    // IDLE and therefore always wins.
    assign serve_s = pending_r && (nextState_s == IDLE);

    assign bus.fmpsReadoutAddress = addr_r;
    assign bus.uBreadAck          = ubAck_r;
    assign bus.uBreadData         = ubData_r;

    // Clamp the requested node count to the addressable range.
    always_comb begin
        if (fmpsCount > MAX_COUNT) begin
            effCount_s = MAX_COUNT;
        end else begin
            effCount_s = fmpsCount;
        end
        // With n == 2**INDEX_WIDTH the low bits are zero and this wraps to all ones.
        effLast_s = effCount_s[INDEX_WIDTH-1:0] - {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    end

    // Merge the word returned for last cycle's address into the working result.
    always_comb begin
        capBit_s         = capValid_r & bus.fmpsReadout[TRIP_BIT];
        capMask_s        = {{(NODES-1){1'b0}}, capBit_s} << capIdx_r;
        nextWorkBitmap_s = workBitmap_r | capMask_s;
        nextWorkCount_s  = workCount_r + {{INDEX_WIDTH{1'b0}}, capBit_s};
    end

    // FSM state register.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (!start_s) begin
                    nextState_s = IDLE;
                end else if (effCount_s == {(INDEX_WIDTH+1){1'b0}}) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = SWEEP;
                end
            end
            SWEEP: begin
                if (abort_s) begin
                    nextState_s = IDLE;
                end else if (addr_r == lastIdx_r) begin
                    nextState_s = DRAIN;
                end else begin
                    nextState_s = SWEEP;
                end
            end
            DRAIN: begin
                if (abort_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = DONE;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Sweep datapath, port address and published results.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            // Held high so a readoutValid level present across reset is not an edge.
            rvPrev_r     <= 1'b1;
            addr_r       <= {INDEX_WIDTH{1'b0}};
            lastIdx_r    <= {INDEX_WIDTH{1'b0}};
            capValid_r   <= 1'b0;
            capIdx_r     <= {INDEX_WIDTH{1'b0}};
            workBitmap_r <= {NODES{1'b0}};
            workCount_r  <= {(INDEX_WIDTH+1){1'b0}};
            tripBitmap   <= {NODES{1'b0}};
            tripCount    <= {(INDEX_WIDTH+1){1'b0}};
            tripStrobe   <= 1'b0;
            sweepDone    <= 1'b0;
            sweepAborted <= 1'b0;
            busy         <= 1'b0;
            seqno        <= {SEQNO_WIDTH{1'b0}};
        end else begin
            rvPrev_r     <= readoutValid;
            capValid_r   <= (state_r == SWEEP) && !abort_s;
            capIdx_r     <= addr_r;
            sweepAborted <= abort_s;
            busy         <= (nextState_s == SWEEP) || (nextState_s == DRAIN);
            sweepDone    <= 1'b0;
            tripStrobe   <= 1'b0;
            if (start_s) begin
                workBitmap_r <= {NODES{1'b0}};
                workCount_r  <= {(INDEX_WIDTH+1){1'b0}};
                lastIdx_r    <= effLast_s;
            end else begin
                workBitmap_r <= nextWorkBitmap_s;
                workCount_r  <= nextWorkCount_s;
            end
            if (start_s && (nextState_s == SWEEP)) begin
                addr_r <= {INDEX_WIDTH{1'b0}};
            end else if ((state_r == SWEEP) && (nextState_s == SWEEP)) begin
                addr_r <= addr_r + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
            end else if (serve_s) begin
                addr_r <= ubAddr_r;
            end
            if ((nextState_s == DONE) && (state_r != DONE)) begin
                sweepDone <= 1'b1;
                seqno     <= seqno + {{(SEQNO_WIDTH-1){1'b0}}, 1'b1};
                if (state_r == DRAIN) begin
                    tripBitmap <= nextWorkBitmap_s;
                    tripCount  <= nextWorkCount_s;
                    tripStrobe <= (nextWorkCount_s != {(INDEX_WIDTH+1){1'b0}});
                end else begin
                    tripBitmap <= {NODES{1'b0}};
                    tripCount  <= {(INDEX_WIDTH+1){1'b0}};
                end
            end
        end
    end

    // One-deep uB request holder and its read pipeline.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            pending_r <= 1'b0;
            ubAddr_r  <= {INDEX_WIDTH{1'b0}};
            ubFetch_r <= 1'b0;
            ubCap_r   <= 1'b0;
            ubAck_r   <= 1'b0;
            ubData_r  <= 32'h0000_0000;
        end else begin
            if (bus.uBreadStrobe) begin
                pending_r <= 1'b1;
                ubAddr_r  <= bus.uBreadAddress;
            end else if (serve_s) begin
                pending_r <= 1'b0;
            end
            ubFetch_r <= serve_s;
            ubCap_r   <= ubFetch_r;
            ubAck_r   <= ubCap_r;
            if (ubCap_r) begin
                ubData_r <= bus.fmpsReadout;
            end
        end
    end
endmodule
